// File: rtl/stream_pkg.sv
// Shared stream definitions: default widths and the held-word record that
// the packet FIFO carries unchanged as its PACKET_T.
package stream_pkg;

    localparam int DEFAULT_IN_W  = 32;
    localparam int DEFAULT_OUT_W = 8;
    localparam int DEFAULT_RATIO = DEFAULT_IN_W / DEFAULT_OUT_W;
    localparam int DEFAULT_BW    = $clog2(DEFAULT_RATIO);

    // Field order matches {in_data, in_last, in_beats} so a FIFO entry maps 1:1.
    typedef struct packed {
        logic [DEFAULT_IN_W-1:0] data;
        logic                    last;
        logic [DEFAULT_BW-1:0]   end_idx;
    } hold_t;

    function automatic int beat_width(input int in_w, input int out_w);
        int ratio;
        ratio = in_w / out_w;
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/word_unpacker_if.sv
// Word-in / beat-out handshake bundle for the width-down converter.
interface word_unpacker_if
    import stream_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int OUT_W = DEFAULT_OUT_W
) ();

    localparam int BW = beat_width(IN_W, OUT_W);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic [BW-1:0]    in_beats;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, in_last, in_beats, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, in_beats, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/word_unpacker.sv
// Width-down converter: takes full words (optionally partial) and emits them
// lowest beat first, tagging the final beat of a packet with out_last.
module word_unpacker
    import stream_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int OUT_W = DEFAULT_OUT_W
) (
    input logic            clock,
    input logic            reset,
    word_unpacker_if.slave bus
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int BW    = beat_width(IN_W, OUT_W);

    if (RATIO < 2 || (IN_W % OUT_W) != 0) begin : g_bad_ratio
        $error("word_unpacker: IN_W must be a multiple of OUT_W with ratio >= 2");
    end

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    typedef struct packed {
        logic [IN_W-1:0] data;
        logic            last;
        logic [BW-1:0]   end_idx;
    } hold_rec_t;

    logic [0:0]     state;
    logic [0:0]     state_next;
    hold_rec_t      hold;
    logic [BW-1:0]  idx;
    logic           valid;
    logic           ready;
    logic           accept;
    logic           beat_xfer;
    logic           last_beat;

    always_comb begin
        valid     = (state == SEND);
        last_beat = (idx == hold.end_idx);
        beat_xfer = valid && bus.out_ready;
        // A word can be replaced in the same cycle its final beat leaves,
        // which is what lets single-beat words stream at full rate.
        ready     = (state == IDLE) || (beat_xfer && last_beat);
        accept    = bus.in_valid && ready;

        state_next = state;
        if (accept) begin
            state_next = SEND;
        end else if (beat_xfer && last_beat) begin
            state_next = IDLE;
        end
    end

    assign bus.out_valid = valid;
    assign bus.in_ready  = ready;
    assign bus.out_data  = hold.data[idx*OUT_W +: OUT_W];
    assign bus.out_last  = valid && hold.last && last_beat;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                hold.data    <= bus.in_data;
                hold.last    <= bus.in_last;
                hold.end_idx <= bus.in_beats;
                idx          <= '0;
            end else if (beat_xfer && !last_beat) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_unpacker.sv
// Scoreboard bench for word_unpacker: driver pushes expected beats, monitor
// pops and compares every beat the DUT hands over.
module tb_word_unpacker;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       wend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   stamps[$];

    word_unpacker_if #(.IN_W(32), .OUT_W(8)) bus ();

    word_unpacker #(.IN_W(32), .OUT_W(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every transferred beat must be the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (!bus.out_ready) begin
                check("in_ready_stall", {31'd0, bus.in_ready}, 32'd0);
            end else if (sb.size() == 0) begin
                check("unexpected_beat", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                stamps.push_back(cyc);
                check("beat_data", {24'd0, bus.out_data}, {24'd0, e.d});
                check("beat_last", {31'd0, bus.out_last}, {31'd0, e.l});
                check("in_ready_xfer", {31'd0, bus.in_ready}, {31'd0, e.wend});
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] b,
                             output int acc);
        int  n;
        bit  got;
        for (int k = 0; k <= int'(b); k++) begin
            exp_t e;
            e.d    = d[k*8 +: 8];
            e.l    = l && (k == int'(b));
            e.wend = (k == int'(b));
            sb.push_back(e);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_beats = b;
        n   = 0;
        got = 1'b0;
        acc = -1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("accept_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int acc2;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_beats  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(1);

        // Full word, latency and throughput
        stamps.delete();
        send_word(32'hDDCCBBAA, 1'b1, 2'd3, acc);
        drain();
        check("t1_beats", stamps.size(), 32'd4);
        if (stamps.size() == 4) begin
            check("t1_latency", stamps[0], acc + 1);
            check("t1_span", stamps[3] - stamps[0], 32'd3);
        end
        idle(2);

        // Back-to-back full words, no bubble
        stamps.delete();
        send_word(32'h03020100, 1'b0, 2'd3, acc);
        send_word(32'h07060504, 1'b1, 2'd3, acc2);
        drain();
        check("t2_beats", stamps.size(), 32'd8);
        if (stamps.size() == 8) check("t2_span", stamps[7] - stamps[0], 32'd7);
        idle(2);

        // Partial final word
        stamps.delete();
        send_word(32'hFFFF2211, 1'b1, 2'd1, acc);
        drain();
        idle(3);
        check("t3_beats", stamps.size(), 32'd2);

        // Stall on BB
        bus.out_ready = 1'b0;
        send_word(32'hDDCCBBAA, 1'b1, 2'd3, acc);
        bus.out_ready = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_data", {24'd0, bus.out_data}, 32'h000000BB);
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_last", {31'd0, bus.out_last}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();
        idle(2);

        // Stream of single-beat words
        stamps.delete();
        send_word(32'h00000001, 1'b1, 2'd0, acc);
        send_word(32'h00000002, 1'b1, 2'd0, acc2);
        send_word(32'h00000003, 1'b1, 2'd0, acc2);
        drain();
        check("t5_beats", stamps.size(), 32'd3);
        if (stamps.size() == 3) begin
            check("t5_latency", stamps[0], acc + 1);
            check("t5_span", stamps[2] - stamps[0], 32'd2);
        end
        idle(2);

        // Reset while CC is on the output
        send_word(32'hDDCCBBAA, 1'b1, 2'd3, acc);
        idle(2);
        check("pre_rst_data", {24'd0, bus.out_data}, 32'h000000CC);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        stamps.delete();
        send_word(32'h44332211, 1'b1, 2'd3, acc);
        drain();
        idle(3);
        check("post_rst_beats", stamps.size(), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_unpacker.md
# word_unpacker

Width-down converter sitting directly downstream of the packet FIFO: consumes full-width words over a valid/ready handshake and emits them as a sequence of narrower beats, lowest-order beat first. Supports partial final words (fewer than RATIO beats valid) and propagates a packet-end marker onto the last emitted beat. Used to drive byte-wide consumers from the 32-bit FIFO without bubbles.

## Interface
- IN_W, default 32: input word width; must be an integer multiple of OUT_W.
- OUT_W, default 8: output beat width.
- RATIO, derived = IN_W/OUT_W: beats per full word; must be >= 2 (elaboration error otherwise).
- BW, derived = $clog2(RATIO): beat index / count width.
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream word valid (driven from FIFO out_valid).
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_W  word; beat k is in_data[k*OUT_W +: OUT_W].
- in_last  input  1  word is the final word of a packet.
- in_beats  input  BW  number of valid beats minus one (0 = 1 beat, RATIO-1 = full word).
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  OUT_W  current beat.
- out_last  output  1  current beat is the final beat of a packet.

## Operation
- State: IDLE (no word held) / SEND (word held in hold_data, hold_last, hold_end, beat index idx).
- Accept = in_valid && in_ready. On accept: hold_data <= in_data, hold_last <= in_last, hold_end <= in_beats, idx <= 0, state <= SEND.
- in_ready = (state == IDLE) || (out_valid && out_ready && idx == hold_end). Combinational from state and out_ready; no dependence on in_valid.
- out_valid = (state == SEND). out_data = hold_data[idx*OUT_W +: OUT_W]. out_last = out_valid && hold_last && (idx == hold_end).
- Beat transfer = out_valid && out_ready: if idx != hold_end, idx <= idx + 1; else word done: state <= SEND with new word if accept in same cycle, else state <= IDLE.
- Beats beyond hold_end are never emitted; their in_data bits are don't-care.
- idx never exceeds hold_end; no wrap arithmetic beyond BW bits.
- Reset: state <= IDLE, idx <= 0, hold_* <= 0. Any held word is discarded.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
- Latency: word accepted in cycle N -> first beat presented (out_valid = 1) in cycle N+1.
- Throughput: a word of (in_beats+1) beats occupies the output for exactly in_beats+1 cycles under continuous out_ready; back-to-back words produce no idle cycle between last beat of word k and first beat of word k+1.
- Stall: while out_valid && !out_ready, out_data, out_last and idx hold steady; in_ready = 0 when in SEND.
- Single-beat word (in_beats = 0): in_ready is high in every cycle its one beat transfers, so 1-beat words stream at one per cycle.
- Simultaneous last-beat transfer and accept: new word loaded, idx reset to 0, out_valid stays 1.
- Reset asserted mid-word: next cycle out_valid = 0, in_ready = 1; remaining beats are lost.

## Structure
- Shared package stream_pkg: localparams for default IN_W/OUT_W, and typedef for the hold-register record (data, last, end index) so the FIFO's PACKET_T can carry {in_data, in_last, in_beats} unchanged.
- Single module, no sub-modules; the FIFO instance lives in the parent and connects packet_out/out_valid/out_ready to this block's in_* side.
- Two-state FSM in one always_ff plus one always_comb for next-state and handshakes.

## Test plan
- After reset, in_data = 32'hDDCCBBAA, in_beats = 3, in_last = 1, out_ready = 1 -> beats AA, BB, CC, DD on cycles N+1..N+4; out_last only with DD; in_ready high with DD.
- Two full words 32'h03020100 then 32'h07060504 (in_last 0, 1) back-to-back -> eight consecutive beats 00..07, no gap, out_last only on 07.
- Partial word in_beats = 1, in_data = 32'hFFFF2211, in_last = 1 -> beats 11, 22 only; out_last on 22; FF never appears.
- Stall: hold out_ready = 0 for 3 cycles at beat BB of 32'hDDCCBBAA -> out_data stays BB, in_ready = 0 throughout, sequence resumes CC, DD.
- Stream of 1-beat words (in_beats = 0) values 01, 02, 03 with continuous valid/ready -> one beat per cycle, in_ready constantly 1.
- Assert reset while emitting CC of 32'hDDCCBBAA -> next cycle out_valid = 0, in_ready = 1; DD never emitted; subsequent word unpacks correctly from beat 0.
